alu_seq_unit: RTL

Multi-cycle execute unit that sits directly downstream of the ALU decoder. It consumes the 4-bit ALU select code together with two operands and returns a registered result over a valid/ready handshake. Arithmetic and logic ops complete in one cycle. Shifts run on an iterative 1-bit-per-cycle shifter unless the fast barrel shifter is compiled in. It replaces the purely combinational ALU where area matters more than shift latency.

---
 rtl/alu_pkg.sv | 58 +++++
 rtl/alu_seq_unit_if.sv | 30 +++
 rtl/alu_serial_shifter.sv | 71 +++++++
 rtl/alu_seq_unit.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU decoder and the sequential execute unit.
//   - ALU select codes (ALU_ADD .. ALU_AND); codes 1010-1111 are unused
//     and execute as "result 0".
//   - FSM state encoding for alu_seq_unit.
//   - Shift-kind encoding used by the serial shifter.
//   - Small decode helpers for shift ops.
// Build option: ALU_FAST_SHIFT_EN removes the SHIFT state, because shifts
// then complete in one cycle.
// ---------------------------------------------------------------------------
package alu_pkg;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLT  = 4'b0010;
    localparam logic [3:0] ALU_SLTU = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

`ifdef ALU_FAST_SHIFT_EN
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DONE = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;
`endif

    typedef enum logic [1:0] {
        SH_SLL = 2'd0,
        SH_SRL = 2'd1,
        SH_SRA = 2'd2
    } shift_kind_t;

    function automatic logic is_shift_op(input logic [3:0] sel);
        return (sel == ALU_SLL) || (sel == ALU_SRL) || (sel == ALU_SRA);
    endfunction

    function automatic shift_kind_t sel_to_shift_kind(input logic [3:0] sel);
        shift_kind_t kind;
        case (sel)
            ALU_SRL: kind = SH_SRL;
            ALU_SRA: kind = SH_SRA;
            default: kind = SH_SLL;
        endcase
        return kind;
    endfunction

endpackage

// File: rtl/alu_seq_unit_if.sv
// ---------------------------------------------------------------------------
// alu_seq_unit_if
// Request/response bundle between the ALU decoder stage (master) and the
// sequential execute unit (slave).
//   in_valid/in_ready   request handshake, alu_sel/op_a/op_b payload
//   out_valid/out_ready response handshake, result/zero payload
// ---------------------------------------------------------------------------
interface alu_seq_unit_if #(
    parameter int XLEN = 32
) ();
    logic            in_valid;
    logic            in_ready;
    logic [3:0]      alu_sel;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;
    logic            zero;

    modport master (
        output in_valid, alu_sel, op_a, op_b, out_ready,
        input  in_ready, out_valid, result, zero
    );

    modport slave (
        input  in_valid, alu_sel, op_a, op_b, out_ready,
        output in_ready, out_valid, result, zero
    );
endinterface

// File: rtl/alu_serial_shifter.sv
// ---------------------------------------------------------------------------
// alu_serial_shifter
// Iterative 1-bit-per-cycle shifter.
//   clk, rst_n  clock, asynchronous active-low reset (clears acc and cnt)
//   load        capture din into acc, shamt into cnt, op into the kind reg
//   shamt       number of single-bit steps to perform (must be non-zero)
//   op          shift kind (SLL / SRL / SRA)
//   din         value to shift
//   last        high during the cycle that performs the final step
//   dout        acc shifted by one more bit; equals the final result while
//               last is high
// Not instantiated when ALU_FAST_SHIFT_EN is defined.
// ---------------------------------------------------------------------------
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic [SHW-1:0]  shamt,
    input  shift_kind_t     op,
    input  logic [XLEN-1:0] din,
    output logic            last,
    output logic [XLEN-1:0] dout
);

    logic [XLEN-1:0] acc_reg;
    logic [SHW-1:0]  cnt_reg;
    shift_kind_t     op_reg;
    logic [XLEN-1:0] shifted;

    // One-bit shift network: every bit takes its left or right neighbour;
    // the vacated end gets 0, or the sign bit for an arithmetic right shift.
    for (genvar gi = 0; gi < XLEN; gi++) begin : g_bit
        logic left_in;
        logic right_in;
        if (gi == 0) begin : g_lsb
            assign left_in = 1'b0;
        end else begin : g_mid_l
            assign left_in = acc_reg[gi-1];
        end
        if (gi == XLEN - 1) begin : g_msb
            assign right_in = (op_reg == SH_SRA) ? acc_reg[XLEN-1] : 1'b0;
        end else begin : g_mid_r
            assign right_in = acc_reg[gi+1];
        end
        assign shifted[gi] = (op_reg == SH_SLL) ? left_in : right_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_reg <= '0;
            cnt_reg <= '0;
            op_reg  <= SH_SLL;
        end else if (load) begin
            acc_reg <= din;
            cnt_reg <= shamt;
            op_reg  <= op;
        end else if (cnt_reg != '0) begin
            acc_reg <= shifted;
            cnt_reg <= cnt_reg - SHW'(1);
        end
    end

    assign last = (cnt_reg == SHW'(1));
    assign dout = shifted;

endmodule

// File: rtl/alu_seq_unit.sv
// ---------------------------------------------------------------------------
// alu_seq_unit
// Multi-cycle execute unit behind the ALU decoder. Accepts one operation at
// a time and returns a registered result over valid/ready.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; aborts any operation in flight
//   bus    alu_seq_unit_if.slave: in_valid/in_ready + alu_sel/op_a/op_b,
//          out_valid/out_ready + result/zero
// Arithmetic/logic ops and shifts by 0 finish one cycle after accept.
// Shifts by k>0 use the serial shifter and finish k+1 cycles after accept.
// Build option: define ALU_FAST_SHIFT_EN to compute shifts with a barrel
// shifter instead (every op one cycle; no SHIFT state, no serial shifter).
// ---------------------------------------------------------------------------
module alu_seq_unit
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_seq_unit_if.slave  bus
);

    state_t          state_reg;
    state_t          state_next;
    logic [XLEN-1:0] result_reg;
    logic [XLEN-1:0] result_next;
    logic            zero_reg;
    logic            zero_next;
    logic            out_valid_reg;
    logic [XLEN-1:0] alu_value;
    logic [SHW-1:0]  shamt;

    assign shamt = bus.op_b[SHW-1:0];

`ifndef ALU_FAST_SHIFT_EN
    logic            sh_load;
    logic            sh_last;
    logic [XLEN-1:0] sh_dout;

    alu_serial_shifter #(
        .XLEN (XLEN),
        .SHW  (SHW)
    ) u_shifter (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (sh_load),
        .shamt (shamt),
        .op    (sel_to_shift_kind(bus.alu_sel)),
        .din   (bus.op_a),
        .last  (sh_last),
        .dout  (sh_dout)
    );
`endif

    // Single-cycle datapath. In the serial build the shift cases only see
    // shamt==0 (non-zero amounts go to the serial shifter), so they pass
    // op_a through and no barrel shifter is built.
    always_comb begin
        alu_value = '0;
        case (bus.alu_sel)
            ALU_ADD:  alu_value = bus.op_a + bus.op_b;
            ALU_SUB:  alu_value = bus.op_a - bus.op_b;
            ALU_SLT:  alu_value = {{(XLEN-1){1'b0}}, ($signed(bus.op_a) < $signed(bus.op_b))};
            ALU_SLTU: alu_value = {{(XLEN-1){1'b0}}, (bus.op_a < bus.op_b)};
            ALU_XOR:  alu_value = bus.op_a ^ bus.op_b;
`ifdef ALU_FAST_SHIFT_EN
            ALU_SLL:  alu_value = bus.op_a << shamt;
            ALU_SRL:  alu_value = bus.op_a >> shamt;
            ALU_SRA:  alu_value = $unsigned($signed(bus.op_a) >>> shamt);
`else
            ALU_SLL:  alu_value = bus.op_a;
            ALU_SRL:  alu_value = bus.op_a;
            ALU_SRA:  alu_value = bus.op_a;
`endif
            ALU_OR:   alu_value = bus.op_a | bus.op_b;
            ALU_AND:  alu_value = bus.op_a & bus.op_b;
            default:  alu_value = '0;
        endcase
    end

    // Next-state and result update. in_ready is high exactly in IDLE, so
    // in_valid in IDLE is an accept.
    always_comb begin
        state_next  = state_reg;
        result_next = result_reg;
        zero_next   = zero_reg;
`ifndef ALU_FAST_SHIFT_EN
        sh_load     = 1'b0;
`endif
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
`ifndef ALU_FAST_SHIFT_EN
                    if (is_shift_op(bus.alu_sel) && (shamt != '0)) begin
                        sh_load    = 1'b1;
                        state_next = SHIFT;
                    end else
`endif
                    begin
                        result_next = alu_value;
                        zero_next   = (alu_value == '0);
                        state_next  = DONE;
                    end
                end
            end
`ifndef ALU_FAST_SHIFT_EN
            SHIFT: begin
                if (sh_last) begin
                    result_next = sh_dout;
                    zero_next   = (sh_dout == '0);
                    state_next  = DONE;
                end
            end
`endif
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            result_reg    <= '0;
            zero_reg      <= 1'b1;
            out_valid_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            result_reg    <= result_next;
            zero_reg      <= zero_next;
            out_valid_reg <= (state_next == DONE);
        end
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = out_valid_reg;
    assign bus.result    = result_reg;
    assign bus.zero      = zero_reg;

endmodule
